// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch constants, fetch FSM state type and buffer entry layout
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ILLEGAL_INSTR    = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: two-entry instruction buffer with push, pop and flush; head is registered
module ifu_fifo
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] din,
    output logic [63:0] head,
    output logic [1:0]  count
);

    fetch_entry_t e0, e1;

    assign head = e0;

    // e0 is the head; on a pop from a full buffer e1 shifts forward and the new word lands behind it
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else begin
            e0    <= (pop && count == 2'd2) ? e1 :
                     (push && (count == 2'd0 || pop)) ? fetch_entry_t'(din) : e0;
            e1    <= (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop))) ? fetch_entry_t'(din) : e1;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencing, redirect and illegal-word halt in front of a 2-entry buffer
// Optional macro IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
module instr_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
`ifdef IFU_PERF_CNT_EN
    output logic        halted,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`else
    output logic        halted
`endif
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d;
    logic [1:0]   count;
    logic [63:0]  head;
    fetch_entry_t head_e;
    logic         pop, illegal, slot, push;

    assign imem_addr = pc & WORD_MASK;
    assign pop       = out_valid && out_ready;
    assign illegal   = imem_rdata == ILLEGAL_INSTR;
    assign slot      = state == RUN && (count != FULL || pop);
    assign push      = slot && !illegal && !redirect_valid;
    assign head_e    = fetch_entry_t'(head);
    assign out_valid = count != 2'd0;
    assign out_instr = out_valid ? head_e.instr : '0;
    assign out_pc    = out_valid ? head_e.pc : '0;
    assign halted    = state == HALT;

    // next state: redirect wins, an all-zero word stops fetch, otherwise advance on each push
    always_comb begin
        state_d = state;
        pc_d    = pc;
        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = redirect_pc & WORD_MASK;
        end else if (state == RUN && illegal) begin
            state_d = HALT;
        end else if (push) begin
            pc_d = pc + PC_INC;
        end
    end

    // state and pc registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_d;
            pc    <= pc_d;
        end
    end

    ifu_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({imem_rdata, imem_addr}),
        .head  (head),
        .count (count)
    );

`ifdef IFU_PERF_CNT_EN
    // free-running event counters: buffered fetches and redirects
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + {31'b0, push};
            perf_flush_cnt <= perf_flush_cnt + {31'b0, redirect_valid};
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed scenarios plus random traffic against a queue-based fetch model
module tb_instr_fetch_ctrl;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;
    logic        halted;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

    logic [31:0] mem [64];
    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_halt;
    int unsigned m_fetch, m_flush;
    int          n_vec = 0;
    int          n_err = 0;

    assign imem_rdata = mem[imem_addr[7:2]];

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.RESET_PC(TB_RESET_PC), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
`ifdef IFU_PERF_CNT_EN
        .halted         (halted),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`else
        .halted         (halted)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_model();
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        check("out_instr", out_instr, q.size() != 0 ? q[0].instr : 32'h0);
        check("out_pc", out_pc, q.size() != 0 ? q[0].pc : 32'h0);
        check("halted", {31'b0, halted}, {31'b0, m_halt});
`ifdef IFU_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_flush", perf_flush_cnt, m_flush);
`endif
    endtask

    task automatic model_clock(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
        int          n;
        bit          popped;
        logic [31:0] w;
        if (!r) begin
            q.delete();
            m_pc    = TB_RESET_PC & 32'hFFFF_FFFC;
            m_halt  = 0;
            m_fetch = 0;
            m_flush = 0;
        end else if (rv) begin
            q.delete();
            m_pc   = rp & 32'hFFFF_FFFC;
            m_halt = 0;
            m_flush++;
        end else begin
            n      = q.size();
            popped = rd && n > 0;
            w      = mem[m_pc[7:2]];
            if (popped) void'(q.pop_front());
            if (!m_halt) begin
                if (w == 32'h0) m_halt = 1;
                else if (n < 2 || popped) begin
                    q.push_back('{w, m_pc});
                    m_pc = m_pc + 32'd4;
                    m_fetch++;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rd;
        @(negedge clk);
        compare_model();
        model_clock(r, rv, rp, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        mem[0] = 32'h0064A423;
        mem[1] = 32'h00B62423;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clock(1'b0, 1'b0, 32'h0, 1'b0);

        // first fetch right after reset release, streaming consumer
        step(1, 0, 0, 1);
        check("r33_pc0", out_pc, 32'h0);
        check("r33_instr0", out_instr, 32'h0064A423);
        step(1, 0, 0, 1);
        check("r33_pc4", out_pc, 32'h4);
        check("r33_instr4", out_instr, 32'h00B62423);
        check("r33_valid", {31'b0, out_valid}, 32'h1);

        // stalled consumer: buffer fills, address holds, a single pop fetches one word
        step(0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0);
        check("r34_hold", imem_addr, 32'h8);
        check("r34_head", out_pc, 32'h0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        check("r34_one", imem_addr, 32'hC);

        // redirect with full buffer and simultaneous pop
        step(1, 1, 32'h0000_0042, 1);
        check("r35_bubble", {31'b0, out_valid}, 32'h0);
        check("r35_addr", imem_addr, 32'h40);
        step(1, 0, 0, 1);
        check("r35_pc", out_pc, 32'h40);
        check("r35_valid", {31'b0, out_valid}, 32'h1);

        // halt on all-zero word, then redirect resumes
        mem[2] = 32'h0;
        step(0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 1);
        check("r36_halted", {31'b0, halted}, 32'h1);
        check("r36_addr", imem_addr, 32'h8);
        step(1, 0, 0, 1);
        check("r36_frozen", imem_addr, 32'h8);
        step(1, 1, 32'h0, 1);
        check("r36_resume", {31'b0, halted}, 32'h0);
        check("r36_addr0", imem_addr, 32'h0);
        step(1, 0, 0, 1);
        check("r36_pc0", out_pc, 32'h0);

        // reset while halted with two buffered entries
        step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        check("r37_pre_halt", {31'b0, halted}, 32'h1);
        check("r37_pre_valid", {31'b0, out_valid}, 32'h1);
        step(0, 1, 32'h80, 1);
        check("r37_valid", {31'b0, out_valid}, 32'h0);
        check("r37_halted", {31'b0, halted}, 32'h0);
        check("r37_addr", imem_addr, TB_RESET_PC);

        // PC wraps modulo 2^32
        mem[2] = 32'h1357_9BDF;
        step(1, 1, 32'hFFFF_FFF8, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc", out_pc, 32'hFFFF_FFFC);

`ifdef IFU_PERF_CNT_EN
        // two redirects then ten fetches from reset
        step(0, 0, 0, 0);
        step(1, 1, 32'h0, 1);
        step(1, 1, 32'h0, 1);
        repeat (10) step(1, 0, 0, 1);
        check("r38_fetch", perf_fetch_cnt, 32'd10);
        check("r38_flush", perf_flush_cnt, 32'd2);
`endif

        // random traffic with sparse illegal words
        for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 15) == 0,
                 $urandom, $urandom_range(0, 3) != 0);
            if (i % 500 == 0) mem[$urandom_range(0, 63)] = $urandom | 32'h1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter: BUF_DEPTH, 2, instruction buffer entries; only the value 2 is supported.
REQ-003 Port: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-low (0 = reset).
REQ-005 Port: imem_addr  out  32  word-aligned fetch address to the instruction memory A port.
REQ-006 Port: imem_rdata  in  32  instruction from the memory RD port; combinational in imem_addr.
REQ-007 Port: redirect_valid  in  1  branch/jump redirect request from execute.
REQ-008 Port: redirect_pc  in  32  redirect target byte address.
REQ-009 Port: out_valid  out  1  buffer head holds a valid instruction.
REQ-010 Port: out_ready  in  1  decode accepts the head this cycle.
REQ-011 Port: out_instr  out  32  instruction at the buffer head.
REQ-012 Port: out_pc  out  32  byte address of out_instr.
REQ-013 Port: halted  out  1  fetch stopped on an illegal all-zero word.

Function
REQ-014 The block SHALL hold PC register pc; imem_addr SHALL equal {pc[31:2],2'b00} combinationally.
REQ-015 FSM states: RUN, HALT; no other encodings reachable.
REQ-016 Transfer: out_valid && out_ready SHALL pop the head at the clock edge.
REQ-017 RUN fetch: when count<2, or count==2 with a pop in the same cycle, {imem_rdata, pc} SHALL be pushed and pc SHALL advance by 4.
REQ-018 With count==2 and no pop, pc and the buffer SHALL hold; imem_addr stays stable.
REQ-019 Latency: the word fetched at edge N SHALL appear on out_instr/out_pc with out_valid=1 after edge N.
REQ-020 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-021 In RUN, imem_rdata==32'h0000_0000 SHALL NOT be pushed; pc holds; FSM goes to HALT; halted=1 from the next cycle.
REQ-022 In HALT, no fetch occurs; buffered entries SHALL still drain via out_ready.
REQ-023 redirect_valid=1 SHALL, at the edge: flush all entries (count=0), set pc={redirect_pc[31:2],2'b00}, and enter RUN (halted=0).
REQ-024 Redirect SHALL take priority over a simultaneous push and pop; the popped head is discarded and nothing is pushed that cycle.
REQ-025 Redirect penalty: out_valid SHALL be 0 the cycle after a redirect edge and 1 (target instruction) the cycle after that, unless the target word is 0.
REQ-026 out_instr/out_pc SHALL be 0 whenever out_valid=0.

Reset
REQ-027 When rst=0 at an edge: pc=RESET_PC, count=0, FSM=RUN, halted=0, out_valid=0, out_instr=0, out_pc=0.
REQ-028 Reset SHALL override redirect, push and pop in the same cycle, including mid-HALT or with a full buffer.
REQ-029 The first fetch SHALL occur at the first edge with rst=1.

Configuration
REQ-030 Macro IFU_PERF_CNT_EN: when defined, outputs perf_fetch_cnt[31:0] (pushes) and perf_flush_cnt[31:0] (redirects) SHALL exist, reset to 0 and wrap at 2^32; when undefined, neither port nor counter logic exists and all other behaviour is identical.

Structure
REQ-031 Shared package riscv_pkg SHALL hold: RESET_PC default, ILLEGAL_INSTR=32'h0000_0000, the fetch FSM state type, and the PC increment constant 4.
REQ-032 The 2-entry buffer SHALL be the sub-module ifu_fifo (push, pop, flush, count, head data); controller logic stays in instr_fetch_ctrl.

Verification
REQ-033 Reset release, mem[0]=32'h0064A423, mem[1]=32'h00B62423, out_ready=1 -> out_pc=0 then 4 on consecutive cycles, out_instr matching, out_valid continuous.
REQ-034 out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 32'h8; a single pop then fetches exactly one word from 0x8.
REQ-035 redirect_valid=1, redirect_pc=32'h0000_0042 with buffer full and out_ready=1 -> next cycle out_valid=0, imem_addr=32'h40; following cycle out_pc=32'h40.
REQ-036 mem[2]=32'h0 -> entries 0x0 and 0x4 delivered, halted=1, pc=0x8 frozen; redirect to 0x0 -> halted=0, fetch resumes at 0x0.
REQ-037 rst=0 asserted for one cycle with 2 buffered entries and HALT active -> out_valid=0, halted=0, imem_addr=RESET_PC next cycle.
REQ-038 With IFU_PERF_CNT_EN defined, 10 fetches and 2 redirects from reset -> perf_fetch_cnt=10, perf_flush_cnt=2.
